vector_register_file: RTL

- Parametrised multi-lane register file for the vector/AI datapath.
- Two write ports: wr0 for ALU results, wr1 for long-latency writeback.
- Per-lane write masks, optional same-cycle write-to-read bypass, hardwired zero register.
- A scoreboard of pending long-latency writes, with a busy counter, used by issue logic for hazard stalls.

---
 rtl/vector_register_file_if.sv | 47 ++++
 rtl/vector_register_file.sv | 105 ++++++++++
 2 files changed

// File: rtl/vector_register_file_if.sv
// Bundles the read, write, reservation and scoreboard signals of the vector register file.
// The master drives addresses, write data and reservations; the slave returns read data and busy status.
interface vector_register_file_if #(
    parameter int DATA_W = 128,
    parameter int LANE_W = 32,
    parameter int ADDR_W = 5
);
    localparam int LANES = DATA_W / LANE_W;

    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;

    logic              wr0_en;
    logic [ADDR_W-1:0] wr0_addr;
    logic [LANES-1:0]  wr0_mask;
    logic [DATA_W-1:0] wr0_data;

    logic              wr1_en;
    logic [ADDR_W-1:0] wr1_addr;
    logic [LANES-1:0]  wr1_mask;
    logic [DATA_W-1:0] wr1_data;

    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_conflict;
    logic [ADDR_W:0]   busy_count;

    modport master (
        output rd_addr1, rd_addr2,
        output wr0_en, wr0_addr, wr0_mask, wr0_data,
        output wr1_en, wr1_addr, wr1_mask, wr1_data,
        output rsv_en, rsv_addr,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, rsv_conflict, busy_count
    );

    modport slave (
        input  rd_addr1, rd_addr2,
        input  wr0_en, wr0_addr, wr0_mask, wr0_data,
        input  wr1_en, wr1_addr, wr1_mask, wr1_data,
        input  rsv_en, rsv_addr,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, rsv_conflict, busy_count
    );
endinterface

// File: rtl/vector_register_file.sv
// Multi-lane register file: two masked write ports, two combinational read ports with optional bypass,
// zero-latency reads, and a busy scoreboard with counter that issue logic uses for hazard stalls.
module vector_register_file #(
    parameter int DATA_W   = 128,
    parameter int LANE_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    vector_register_file_if.slave bus
);
    localparam int LANES = DATA_W / LANE_W;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [ADDR_W:0]     count_q, count_d;

    logic wr0_act, wr1_act, rsv_set, cnt_inc, cnt_dec;

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_dat  [2];
    logic              rd_bsy  [2];

    always_comb begin
        wr0_act = bus.wr0_en && !((ZERO_REG != 0) && (bus.wr0_addr == '0));
        wr1_act = bus.wr1_en && !((ZERO_REG != 0) && (bus.wr1_addr == '0));
        rsv_set = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));
    end

    // wr1 is applied after wr0 so it wins lanes that both ports claim.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) regs_d[r] = regs_q[r];
        for (int l = 0; l < LANES; l++) begin
            if (wr0_act && bus.wr0_mask[l])
                regs_d[bus.wr0_addr][l*LANE_W +: LANE_W] = bus.wr0_data[l*LANE_W +: LANE_W];
            if (wr1_act && bus.wr1_mask[l])
                regs_d[bus.wr1_addr][l*LANE_W +: LANE_W] = bus.wr1_data[l*LANE_W +: LANE_W];
        end
    end

    // A reservation landing on the address being cleared keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (bus.wr1_en) busy_d[bus.wr1_addr] = 1'b0;
        if (rsv_set)    busy_d[bus.rsv_addr] = 1'b1;
        cnt_inc = rsv_set && !busy_q[bus.rsv_addr];
        cnt_dec = bus.wr1_en && busy_q[bus.wr1_addr] &&
                  !(rsv_set && (bus.rsv_addr == bus.wr1_addr));
        case ({cnt_inc, cnt_dec})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rd_addr[0] = bus.rd_addr1;
        rd_addr[1] = bus.rd_addr2;
        for (int p = 0; p < 2; p++) begin
            rd_dat[p] = regs_q[rd_addr[p]];
            rd_bsy[p] = busy_q[rd_addr[p]];
            if (BYPASS != 0) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wr0_act && (bus.wr0_addr == rd_addr[p]) && bus.wr0_mask[l])
                        rd_dat[p][l*LANE_W +: LANE_W] = bus.wr0_data[l*LANE_W +: LANE_W];
                    if (wr1_act && (bus.wr1_addr == rd_addr[p]) && bus.wr1_mask[l])
                        rd_dat[p][l*LANE_W +: LANE_W] = bus.wr1_data[l*LANE_W +: LANE_W];
                end
                if (bus.wr1_en && (bus.wr1_addr == rd_addr[p])) rd_bsy[p] = 1'b0;
            end
            if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
                rd_dat[p] = '0;
                rd_bsy[p] = 1'b0;
            end
            // Forwarded write data must not leak out while reset is held.
            if (reset) begin
                rd_dat[p] = '0;
                rd_bsy[p] = 1'b0;
            end
        end
    end

    assign bus.rd_data1     = rd_dat[0];
    assign bus.rd_data2     = rd_dat[1];
    assign bus.rd_busy1     = rd_bsy[0];
    assign bus.rd_busy2     = rd_bsy[1];
    assign bus.rsv_conflict = rsv_set && busy_q[bus.rsv_addr];
    assign bus.busy_count   = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end
endmodule
